// File: rtl/kalman_channel_scheduler_if.sv
// Sensor-ingress / filtered-state-egress bundle for kalman_channel_scheduler.
// master: sensor front-end / consumer side. slave: the scheduler.
interface kalman_channel_scheduler_if #(
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH*16-1:0] z;
  logic [NUM_CH-1:0]    z_valid;
  logic [NUM_CH-1:0]    z_ready;
  logic [15:0]          x_out;
  logic [CH_W-1:0]      x_ch;
  logic                 x_valid;
  logic                 busy;

  modport master (
    output z,
    output z_valid,
    input  z_ready,
    input  x_out,
    input  x_ch,
    input  x_valid,
    input  busy
  );

  modport slave (
    input  z,
    input  z_valid,
    output z_ready,
    output x_out,
    output x_ch,
    output x_valid,
    output busy
  );
endinterface

// File: rtl/kalman_channel_scheduler.sv
// Round-robin scheduler sharing one scalar steady-state Kalman update across NUM_CH channels.
// Each grant runs error -> multiply -> saturating write-back (one update per 3 cycles).
// Optional feature macro KALMAN_GAIN_CFG_EN: adds a per-channel gain write port
// (k_wr_en/k_wr_ch/k_wr_data); when undefined every channel uses the constant K_DEFAULT.
module kalman_channel_scheduler #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned K_DEFAULT = 13868
) (
  input  logic                        clk,
  input  logic                        reset,
`ifdef KALMAN_GAIN_CFG_EN
  input  logic                        k_wr_en,
  input  logic [$clog2(NUM_CH)-1:0]   k_wr_ch,
  input  logic [15:0]                 k_wr_data,
`endif
  kalman_channel_scheduler_if.slave   bus
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {StIdle, StMul, StWb} state_e;

  state_e                 state_q, state_d;
  logic [NUM_CH-1:0]      pending_q;
  logic [NUM_CH-1:0]      xfer;
  logic [NUM_CH-1:0]      grant_mask;
  logic signed [15:0]     z_hold_q [NUM_CH];
  logic signed [15:0]     x_mem_q  [NUM_CH];
  logic [CH_W-1:0]        rr_ptr_q;
  logic [CH_W-1:0]        g_ch_q;
  logic [CH_W-1:0]        grant_ch;
  logic [CH_W-1:0]        rr_next;
  logic [CH_W:0]          cand;
  logic                   grant_found;
  logic                   grant;
  logic signed [16:0]     err_q;
  logic [15:0]            k_r_q;
  logic [15:0]            gain_sel;
  logic signed [33:0]     prod_q;
  logic signed [17:0]     corr;
  logic signed [17:0]     sum;
  logic signed [15:0]     sat;
  logic [15:0]            x_out_q;
  logic [CH_W-1:0]        x_ch_q;
  logic                   x_valid_q;

  assign bus.z_ready = ~pending_q;
  assign bus.x_out   = x_out_q;
  assign bus.x_ch    = x_ch_q;
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = (state_q != StIdle);

  assign xfer = bus.z_valid & ~pending_q;

`ifdef KALMAN_GAIN_CFG_EN
  logic [15:0] gain_q [NUM_CH];

  // Per-channel gain table; out-of-range channel writes are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) gain_q[i] <= 16'(K_DEFAULT);
    end else if (k_wr_en && ({1'b0, k_wr_ch} < (CH_W+1)'(NUM_CH))) begin
      gain_q[k_wr_ch] <= k_wr_data;
    end
  end

  assign gain_sel = gain_q[grant_ch];
`else
  assign gain_sel = 16'(K_DEFAULT);
`endif

  // Round-robin search: walk offsets high to low so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    cand        = '0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      cand = {1'b0, rr_ptr_q} + (CH_W+1)'(off);
      if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
      if (pending_q[cand[CH_W-1:0]]) begin
        grant_found = 1'b1;
        grant_ch    = cand[CH_W-1:0];
      end
    end
    rr_next = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
  end

  // FSM next-state: grant only from idle, then two fixed datapath cycles.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          grant   = 1'b1;
          state_d = StMul;
        end
      end
      StMul:   state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign grant_mask = grant ? (NUM_CH'(1) << grant_ch) : '0;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Ingress holding slots: a transfer and a grant on different channels can share a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      for (int i = 0; i < NUM_CH; i++) z_hold_q[i] <= '0;
    end else begin
      pending_q <= (pending_q | xfer) & ~grant_mask;
      for (int i = 0; i < NUM_CH; i++) begin
        if (xfer[i]) z_hold_q[i] <= $signed(bus.z[16*i +: 16]);
      end
    end
  end

  // Write-back arithmetic: floor-shift the Q1.15 product, add, clamp to 16-bit signed.
  // |sum| <= |2*z - x| so 18 bits never overflow.
  always_comb begin
    corr = 18'(prod_q >>> 15);
    sum  = 18'(x_mem_q[g_ch_q]) + corr;
    if (sum > 18'sd32767)       sat = 16'sh7fff;
    else if (sum < -18'sd32768) sat = 16'sh8000;
    else                        sat = sum[15:0];
  end

  // Datapath pipeline: latch error/gain at grant, multiply, then commit state and pulse x_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      g_ch_q    <= '0;
      err_q     <= '0;
      k_r_q     <= '0;
      prod_q    <= '0;
      x_out_q   <= '0;
      x_ch_q    <= '0;
      x_valid_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) x_mem_q[i] <= '0;
    end else begin
      x_valid_q <= 1'b0;
      if (grant) begin
        g_ch_q   <= grant_ch;
        err_q    <= 17'(z_hold_q[grant_ch]) - 17'(x_mem_q[grant_ch]);
        k_r_q    <= gain_sel;
        rr_ptr_q <= rr_next;
      end
      if (state_q == StMul) begin
        prod_q <= 34'(err_q) * 34'($signed({1'b0, k_r_q}));
      end
      if (state_q == StWb) begin
        x_mem_q[g_ch_q] <= sat;
        x_out_q         <= sat;
        x_ch_q          <= g_ch_q;
        x_valid_q       <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_kalman_channel_scheduler.sv
// Self-checking bench for kalman_channel_scheduler: directed cases plus randomized traffic
// against a cycle-level behavioural model built from plain integer arithmetic.
module tb_kalman_channel_scheduler;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned CH_W      = 2;
  localparam int          K_DEFAULT = 13868;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

`ifdef KALMAN_GAIN_CFG_EN
  logic            k_wr_en = 1'b0;
  logic [CH_W-1:0] k_wr_ch = '0;
  logic [15:0]     k_wr_data = '0;
`endif

  kalman_channel_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

  kalman_channel_scheduler #(
    .NUM_CH    (NUM_CH),
    .K_DEFAULT (K_DEFAULT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef KALMAN_GAIN_CFG_EN
    .k_wr_en   (k_wr_en),
    .k_wr_ch   (k_wr_ch),
    .k_wr_data (k_wr_data),
`endif
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int vq_cyc[$];
  int vq_ch[$];
  int vq_out[$];

  // Behavioural model state.
  int m_x[NUM_CH];
  int m_hold[NUM_CH];
  bit m_pend[NUM_CH];
  int m_k[NUM_CH];
  int m_rr, m_phase, m_res, m_gch;
  int m_xo, m_xc;
  bit m_xv;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_x[i] = 0; m_hold[i] = 0; m_pend[i] = 0; m_k[i] = K_DEFAULT;
    end
    m_rr = 0; m_phase = 0; m_res = 0; m_gch = 0;
    m_xo = 0; m_xc = 0; m_xv = 0;
  endtask

  // Full update computed at grant time; the result surfaces two edges later.
  task automatic model_grant(input int c);
    longint p, q;
    int err, s;
    err = m_hold[c] - m_x[c];
    p   = longint'(err) * longint'(m_k[c]);
    q   = p / 32768;
    if (p < 0 && q * 32768 != p) q = q - 1;
    s = m_x[c] + int'(q);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    m_x[c] = s; m_res = s; m_gch = c;
    m_pend[c] = 0;
    m_rr = (c + 1) % NUM_CH;
    m_phase = 2;
  endtask

  task automatic model_edge();
    bit xfer[NUM_CH];
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NUM_CH; i++) xfer[i] = bus.z_valid[i] && !m_pend[i];
    m_xv = 0;
    if (m_phase > 0) begin
      m_phase--;
      if (m_phase == 0) begin
        m_xv = 1; m_xo = m_res; m_xc = m_gch;
      end
    end else begin
      for (int off = 0; off < NUM_CH; off++) begin
        automatic int c = (m_rr + off) % NUM_CH;
        if (m_pend[c]) begin
          model_grant(c);
          break;
        end
      end
    end
`ifdef KALMAN_GAIN_CFG_EN
    if (k_wr_en && int'(k_wr_ch) < NUM_CH) m_k[k_wr_ch] = int'(k_wr_data);
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (xfer[i]) begin
        m_hold[i] = int'($signed(bus.z[16*i +: 16]));
        m_pend[i] = 1;
      end
    end
  endtask

  // One clock: advance the model on the edge, compare all outputs 1 time unit later.
  task automatic step();
    logic [NUM_CH-1:0] exp_ready;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    for (int i = 0; i < NUM_CH; i++) exp_ready[i] = !m_pend[i];
    check_eq("z_ready", longint'(bus.z_ready), longint'(exp_ready));
    check_eq("busy", longint'(bus.busy), longint'(m_phase > 0));
    check_eq("x_valid", longint'(bus.x_valid), longint'(m_xv));
    check_eq("x_out", longint'($signed(bus.x_out)), longint'(m_xo));
    check_eq("x_ch", longint'(bus.x_ch), longint'(m_xc));
    if (bus.x_valid) begin
      vq_cyc.push_back(cyc);
      vq_ch.push_back(int'(bus.x_ch));
      vq_out.push_back(int'($signed(bus.x_out)));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.z_valid = '0;
    step();
    reset = 1'b0;
    vq_cyc.delete(); vq_ch.delete(); vq_out.delete();
  endtask

  // Single-channel transfer, then wait out the 3-edge latency and check the result.
  task automatic single_update(input string tag, input int ch, input int zval, input int exp);
    bus.z[16*ch +: 16] = 16'(zval);
    bus.z_valid = '0;
    bus.z_valid[ch] = 1'b1;
    step();
    bus.z_valid = '0;
    step(); step(); step();
    check_eq({tag, "_valid"}, longint'(bus.x_valid), 1);
    check_eq({tag, "_xout"}, longint'($signed(bus.x_out)), longint'(exp));
    check_eq({tag, "_xch"}, longint'(bus.x_ch), longint'(ch));
  endtask

  int t0;

  initial begin
    bus.z = '0;
    bus.z_valid = '0;
    model_reset();
    step();
    do_reset();
    check_eq("rst_zready", longint'(bus.z_ready), 15);
    check_eq("rst_busy", longint'(bus.busy), 0);
    check_eq("rst_xout", longint'(bus.x_out), 0);

    // Steady-state gain on a fresh channel, then a second sample on the same channel.
    single_update("t1", 0, 10000, 4232);
    single_update("t2", 0, 10000, 6673);

    // Floor rounding on a negative correction.
    do_reset();
    single_update("t3", 1, -100, -43);

    // All channels arrive together: served 0..3, one result every 3 cycles.
    do_reset();
    for (int i = 0; i < NUM_CH; i++) bus.z[16*i +: 16] = 16'(1000 * (i + 1));
    bus.z_valid = '1;
    step();
    t0 = cyc;
    bus.z_valid = '0;
    check_eq("t4_ready_low", longint'(bus.z_ready), 0);
    for (int i = 0; i < 12; i++) step();
    check_eq("t4_count", longint'(vq_ch.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < vq_ch.size()) begin
        check_eq("t4_order", longint'(vq_ch[i]), longint'(i));
        check_eq("t4_timing", longint'(vq_cyc[i] - t0), longint'(3 * (i + 1)));
      end
    end

    // Reset right after a grant drops the update and clears state.
    do_reset();
    bus.z[16*2 +: 16] = 16'(5000);
    bus.z_valid[2] = 1'b1;
    step();
    bus.z_valid = '0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vq_ch.delete(); vq_cyc.delete(); vq_out.delete();
    for (int i = 0; i < 5; i++) step();
    check_eq("t6_no_valid", longint'(vq_ch.size()), 0);
    check_eq("t6_zready", longint'(bus.z_ready), 15);
    check_eq("t6_busy", longint'(bus.busy), 0);
    single_update("t6_xmem", 2, 10000, 4232);

`ifdef KALMAN_GAIN_CFG_EN
    // Maximum gain drives the write-back into both saturation rails.
    do_reset();
    k_wr_en = 1'b1; k_wr_ch = '0; k_wr_data = 16'hffff;
    step();
    k_wr_en = 1'b0;
    single_update("t5_pos", 0, 30000, 32767);
    single_update("t5_neg", 0, -30000, -32768);
`endif

    // Randomized traffic with occasional mid-flight resets.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 249) == 0);
      bus.z_valid = NUM_CH'($urandom);
      bus.z = {$urandom, $urandom};
`ifdef KALMAN_GAIN_CFG_EN
      k_wr_en = ($urandom_range(0, 7) == 0);
      k_wr_ch = CH_W'($urandom);
      k_wr_data = 16'($urandom);
`endif
      step();
    end
    reset = 1'b0;
    bus.z_valid = '0;
`ifdef KALMAN_GAIN_CFG_EN
    k_wr_en = 1'b0;
`endif
    for (int i = 0; i < 20; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
